// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions
// ALUControl encodings and controller states
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'b0000,
    OP_SUB   = 4'b0001,
    OP_AND   = 4'b0010,
    OP_OR    = 4'b0011,
    OP_XOR   = 4'b0100,
    OP_SLT   = 4'b0101,
    OP_SLTU  = 4'b0110,
    OP_SLL   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MUL   = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu iterative datapath
// shared shift-add multiply / restoring divide, one bit per cycle
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_div,
  input  logic             i_run,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CW = $clog2(WIDTH);

  // hi: accumulator (mul) or remainder (div)
  // lo: multiplier (mul) or dividend/quotient (div)
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_op;
  logic             r_div;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_sum  = {1'b0, r_hi} + {1'b0, r_op};
  assign w_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, r_op};

  // one iteration of the selected algorithm
  always_comb begin
    w_hi = r_hi;
    w_lo = r_lo;
    if (r_div) begin
      if (!w_diff[WIDTH]) begin
        w_hi = w_diff[WIDTH-1:0];
        w_lo = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi = w_sh[WIDTH-1:0];
        w_lo = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else if (r_lo[0]) begin
      {w_hi, w_lo} = {w_sum, r_lo[WIDTH-1:1]};
    end else begin
      {w_hi, w_lo} = {1'b0, r_hi, r_lo[WIDTH-1:1]};
    end
  end

  // operand load and per-cycle iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi  <= '0;
      r_lo  <= '0;
      r_op  <= '0;
      r_div <= 1'b0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_hi  <= '0;
      r_div <= i_div;
      r_lo  <= i_div ? i_a : i_b;
      r_op  <= i_div ? i_b : i_a;
      r_cnt <= '0;
    end else if (i_run) begin
      r_hi  <= w_hi;
      r_lo  <= w_lo;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // final step's outputs are captured by the top directly
  assign o_last = i_run && (r_cnt == CW'(WIDTH - 1));
  assign o_hi   = w_hi;
  assign o_lo   = w_lo;

endmodule

// File: rtl/seq_alu.sv
// seq_alu top
// single-cycle ALU plus controller for iterative mul/div
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
);

  localparam int SHW = $clog2(WIDTH);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_hi_sel;

  alu_op_e          w_op;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_alu;
  logic             w_load;
  logic             w_div;
  logic             w_res_ld;
  logic [WIDTH-1:0] w_res;
  logic             w_last;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;

  assign w_op    = alu_op_e'(ALUControl);
  assign w_shamt = B[SHW-1:0];
  assign busy    = (r_state != S_IDLE);

  // single-cycle operations; iterative and reserved codes give 0
  always_comb begin
    w_alu = '0;
    unique case (w_op)
      OP_ADD:  w_alu = A + B;
      OP_SUB:  w_alu = A - B;
      OP_AND:  w_alu = A & B;
      OP_OR:   w_alu = A | B;
      OP_XOR:  w_alu = A ^ B;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, A < B};
      OP_SLL:  w_alu = A << w_shamt;
      OP_SRL:  w_alu = A >> w_shamt;
      OP_SRA:  w_alu = WIDTH'($signed(A) >>> w_shamt);
      default: w_alu = '0;
    endcase
  end

  // next state, iterator load and result capture
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_div       = 1'b0;
    w_res_ld    = 1'b0;
    w_res       = r_result;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          unique case (w_op)
            OP_MUL, OP_MULHU: begin
              w_state_nxt = S_MUL;
              w_load      = 1'b1;
            end
            OP_DIVU, OP_REMU: begin
              w_state_nxt = S_DIV;
              w_load      = 1'b1;
              w_div       = 1'b1;
            end
            default: begin
              w_res_ld = 1'b1;
              w_res    = w_alu;
            end
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
          w_res_ld    = 1'b1;
          w_res       = r_hi_sel ? w_hi : w_lo;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, done pulse and registered result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_done   <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_hi_sel <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_res_ld;
      if (w_res_ld) begin
        r_result <= w_res;
        r_zero   <= (w_res == '0);
      end
      if (w_load) begin
        r_hi_sel <= (w_op == OP_MULHU) || (w_op == OP_REMU);
      end
    end
  end

  seq_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_div  (w_div),
    .i_run  (busy),
    .i_a    (A),
    .i_b    (B),
    .o_last (w_last),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  assign done   = r_done;
  assign Result = r_result;
  assign Zero   = r_zero;

endmodule

// File: tb/tb_seq_alu.sv
// seq_alu testbench
// directed and random ops against an arithmetic reference model
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  ALUControl = 4'd0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  seq_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ALUControl (ALUControl),
    .A          (A),
    .B          (B),
    .busy       (busy),
    .done       (done),
    .Result     (Result),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [3:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    int unsigned sh;
    sh = b % 32;
    p  = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return (a < b) ? 32'd1 : 32'd0;
      4'd7:  return a << sh;
      4'd8:  return a >> sh;
      4'd9:  return 32'($signed(a) >>> sh);
      4'd10: return p[31:0];
      4'd11: return p[63:32];
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op >= 4'd10 && op <= 4'd13) ? 33 : 1;
  endfunction

  // called #1 after an edge with busy=0; returns in the done cycle
  task automatic do_op(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res,
                       output logic z, output int lat, output int bcnt);
    start = 1'b1;
    ALUControl = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      lat++;
    end
    res = Result;
    z = Zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (Result !== 32'd0) begin
      errors++; $display("FAIL reset_result got %h want 0", Result);
    end
    checks++;
    if (Zero !== 1'b1) begin
      errors++; $display("FAIL reset_zero got %b want 1", Zero);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [3:0]  ops [12] = '{0, 1, 5, 6, 9, 10, 11, 12, 13, 12, 13, 14};
    logic [31:0] as  [12] = '{5, 3, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              100, 100, 9, 9, 32'h1234};
    logic [31:0] bs  [12] = '{7, 3, 1, 1, 36, 2, 2, 7, 7, 0, 0, 5};
    logic [31:0] rs  [12] = '{12, 0, 1, 0, 32'hF8000000, 32'hFFFFFFFE,
                              1, 14, 2, 32'hFFFFFFFF, 9, 0};
    logic [31:0] res;
    logic z;
    int lat, bc, el;
    for (int i = 0; i < 12; i++) begin
      do_op(ops[i], as[i], bs[i], res, z, lat, bc);
      el = exp_lat(ops[i]);
      checks++;
      if (res !== rs[i] || z !== (rs[i] == 0)) begin
        errors++;
        $display("FAIL dir%0d result got %h/%b want %h", i, res, z, rs[i]);
      end
      checks++;
      if (lat != el || bc != el - 1) begin
        errors++;
        $display("FAIL dir%0d latency got %0d busy %0d want %0d",
                 i, lat, bc, el);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b, e, res;
    logic z;
    int lat, bc, el;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'($urandom_range(0, 20));
        1: b = 32'd0;
        default: b = $urandom;
      endcase
      e  = model(op, a, b);
      el = exp_lat(op);
      do_op(op, a, b, res, z, lat, bc);
      checks++;
      if (res !== e || z !== (e == 0)) begin
        errors++;
        $display("FAIL rnd op%0d a=%h b=%h got %h/%b want %h",
                 op, a, b, res, z, e);
      end
      checks++;
      if (lat != el || bc != el - 1) begin
        errors++;
        $display("FAIL rnd_lat op%0d got %0d busy %0d want %0d",
                 op, lat, bc, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b, e;
    for (int i = 0; i < 12; i++) begin
      op = 4'($urandom_range(0, 9));
      a = $urandom;
      b = $urandom;
      e = model(op, a, b);
      start = 1'b1;
      ALUControl = op;
      A = a;
      B = b;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1 || Result !== e) begin
        errors++;
        $display("FAIL b2b%0d done %b got %h want %h", i, done, Result, e);
      end
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL b2b_pulse done got %b want 0", done);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] a, b, e;
    int lat;
    a = $urandom;
    b = $urandom;
    e = model(4'd11, a, b);
    start = 1'b1;
    ALUControl = 4'd11;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 1;
    repeat (4) begin @(posedge clk); #1; lat++; end
    start = 1'b1;
    ALUControl = 4'd0;
    A = 32'd1;
    B = 32'd2;
    repeat (3) begin @(posedge clk); #1; lat++; end
    start = 1'b0;
    while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
    checks++;
    if (lat != 33 || Result !== e) begin
      errors++;
      $display("FAIL busy_ignore lat %0d got %h want 33 %h", lat, Result, e);
    end
  endtask

  task automatic test_start_on_done();
    logic [31:0] res, a, b;
    logic z;
    int lat, bc;
    do_op(4'd12, 32'd1000, 32'd9, res, z, lat, bc);
    a = $urandom;
    b = $urandom;
    start = 1'b1;
    ALUControl = 4'd4;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || Result !== (a ^ b) || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_on_done done %b got %h want %h", done, Result,
               a ^ b);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    logic z;
    int lat, bc, nd;
    do_op(4'd0, 32'd40, 32'd2, res, z, lat, bc);
    start = 1'b1;
    ALUControl = 4'd12;
    A = 32'd5000;
    B = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    start = 1'b1;
    ALUControl = 4'd0;
    A = 32'd8;
    B = 32'd8;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Result !== 32'd0
        || Zero !== 1'b1) begin
      errors++;
      $display("FAIL reset_abort busy %b done %b got %h want 0",
               busy, done, Result);
    end
    reset = 1'b0;
    nd = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++; $display("FAIL abort_no_done got %0d pulses want 0", nd);
    end
    do_op(4'd0, 32'd1, 32'd1, res, z, lat, bc);
    checks++;
    if (res !== 32'd2 || lat != 1) begin
      errors++;
      $display("FAIL post_reset_add got %h lat %0d want 2 lat 1", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_start_on_done();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
